instr_fetch_aligner: RTL and testbench

//  Fetch stage directly upstream of InstMem: drives its word address, takes its 32-bit read data and

---
 rtl/instr_fetch_aligner.sv | 138 +++++++++++++
 tb/tb_instr_fetch_aligner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_aligner.sv
// Fetch stage in front of a combinational-read instruction memory.
// Produces one aligned RV32IC instruction per decode handshake. A 16-bit
// hold buffer carries the upper halfword of the last fetched word, so
// compressed instructions and 32-bit instructions that straddle a word
// boundary both come out without stalling.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_EMPTY | hold buffer unused; instruction starts in the current word
//          | (pc[1]=1 here means one bubble to load the upper halfword)
//  S_HOLD  | hold buffer holds the halfword at pc; the current word
//          | supplies the upper half of a 32-bit instruction if needed
module instr_fetch_aligner #(
   parameter int                ADDR_W   = 6,
   parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W+1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W+1:0] out_pc,
   output logic              out_is_compressed
);

   localparam int PW = ADDR_W + 2;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       pc_q, pc_d;
   logic [ADDR_W-1:0]   fetch_word_q, fetch_word_d;
   logic [15:0]         hold_q, hold_d;

   logic                lo_is_c;
   logic                hold_is_c;
   logic                handshake;

   assign lo_is_c   = (imem_data[1:0] != 2'b11);
   assign hold_is_c = (hold_q[1:0] != 2'b11);
   assign handshake = out_valid & out_ready;

   assign imem_addr = fetch_word_q;
   assign out_pc    = pc_q;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_EMPTY;
         pc_q         <= RESET_PC;
         fetch_word_q <= RESET_PC[PW-1:2];
         hold_q       <= 16'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_word_q <= fetch_word_d;
         hold_q       <= hold_d;
      end
   end

   // Next-state: redirect wins, otherwise advance only on a handshake
   // (or unconditionally when priming the hold buffer for an odd pc).
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_word_d = fetch_word_q;
      hold_d       = hold_q;
      if (redirect_valid) begin
         pc_d         = {redirect_pc[PW-1:1], 1'b0};
         fetch_word_d = redirect_pc[PW-1:2];
         state_d      = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (pc_q[1]) begin
                  hold_d       = imem_data[31:16];
                  fetch_word_d = fetch_word_q + ADDR_W'(1);
                  state_d      = S_HOLD;
               end else if (handshake) begin
                  fetch_word_d = fetch_word_q + ADDR_W'(1);
                  if (lo_is_c) begin
                     pc_d    = pc_q + PW'(2);
                     hold_d  = imem_data[31:16];
                     state_d = S_HOLD;
                  end else begin
                     pc_d    = pc_q + PW'(4);
                  end
               end
            end
            S_HOLD: begin
               if (handshake) begin
                  if (hold_is_c) begin
                     pc_d    = pc_q + PW'(2);
                     state_d = S_EMPTY;
                  end else begin
                     pc_d         = pc_q + PW'(4);
                     hold_d       = imem_data[31:16];
                     fetch_word_d = fetch_word_q + ADDR_W'(1);
                  end
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Output decode; nothing is offered during reset or a redirect cycle.
   always_comb begin
      out_valid         = 1'b0;
      out_instr         = 32'h0;
      out_is_compressed = 1'b0;
      if (rst && !redirect_valid) begin
         case (state_q)
            S_EMPTY: begin
               if (!pc_q[1]) begin
                  out_valid         = 1'b1;
                  out_instr         = lo_is_c ? {16'h0, imem_data[15:0]} : imem_data;
                  out_is_compressed = lo_is_c;
               end
            end
            S_HOLD: begin
               out_valid         = 1'b1;
               out_instr         = hold_is_c ? {16'h0, hold_q} : {imem_data[15:0], hold_q};
               out_is_compressed = hold_is_c;
            end
            default: out_valid = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Directed bench for instr_fetch_aligner with a combinational memory model.
module tb_instr_fetch_aligner;

   localparam int ADDR_W = 6;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              redirect_valid;
   logic [ADDR_W+1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W+1:0] out_pc;
   logic              out_is_compressed;

   logic [31:0] mem [0:63];
   int total;
   int bad;

   assign imem_data = mem[imem_addr];

   instr_fetch_aligner #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_instr         (out_instr),
      .out_pc            (out_pc),
      .out_is_compressed (out_is_compressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      total++;
      if (imem_addr !== 6'd0) begin
         bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr);
      end
      rst = 1'b1; #1;
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc} !== {1'b1, 1'b0, 32'h00500093, 8'h00}) begin
         bad++; $display("FAIL release_out got v=%b c=%b i=%h pc=%h exp v=1 c=0 i=00500093 pc=00",
                         out_valid, out_is_compressed, out_instr, out_pc);
      end
   endtask

   task automatic test_compressed_pair();
      out_ready = 1'b1;
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00000505, 8'h04, 6'd1}) begin
         bad++; $display("FAIL c_at_4 got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00000505 pc=04 a=1",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00000001, 8'h06, 6'd2}) begin
         bad++; $display("FAIL c_at_6 got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00000001 pc=06 a=2",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_split_32();
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00004501, 8'h08, 6'd2}) begin
         bad++; $display("FAIL c_at_8 got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00004501 pc=08 a=2",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b0, 32'h00500093, 8'h0A, 6'd3}) begin
         bad++; $display("FAIL split_at_a got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=0 i=00500093 pc=0a a=3",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({out_valid, out_instr, out_pc, imem_addr} !== {1'b1, 32'h00500093, 8'h0A, 6'd3}) begin
            bad++; $display("FAIL stall_%0d got v=%b i=%h pc=%h a=%0d exp v=1 i=00500093 pc=0a a=3",
                            i, out_valid, out_instr, out_pc, imem_addr);
         end
      end
      out_ready = 1'b1;
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00004505, 8'h0E, 6'd4}) begin
         bad++; $display("FAIL after_stall got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00004505 pc=0e a=4",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_redirect_odd();
      redirect_valid = 1'b1; redirect_pc = 8'h0E; #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL redir_cycle_valid got=%b exp=0", out_valid);
      end
      tick();
      redirect_valid = 1'b0; #1;
      total++;
      if ({out_valid, out_pc, imem_addr} !== {1'b0, 8'h0E, 6'd3}) begin
         bad++; $display("FAIL redir_bubble got v=%b pc=%h a=%0d exp v=0 pc=0e a=3", out_valid, out_pc, imem_addr);
      end
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00004505, 8'h0E, 6'd4}) begin
         bad++; $display("FAIL redir_out got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00004505 pc=0e a=4",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_wrap();
      mem[63] = {16'h0093, 16'h0000};
      mem[0]  = {16'h1234, 16'h0050};
      redirect_valid = 1'b1; redirect_pc = 8'hFE; #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL wrap_redir_valid got=%b exp=0", out_valid);
      end
      tick();
      redirect_valid = 1'b0; #1;
      total++;
      if ({out_valid, out_pc, imem_addr} !== {1'b0, 8'hFE, 6'd63}) begin
         bad++; $display("FAIL wrap_bubble got v=%b pc=%h a=%0d exp v=0 pc=fe a=63", out_valid, out_pc, imem_addr);
      end
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b0, 32'h00500093, 8'hFE, 6'd0}) begin
         bad++; $display("FAIL wrap_split got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=0 i=00500093 pc=fe a=0",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
      tick();
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00001234, 8'h02, 6'd1}) begin
         bad++; $display("FAIL wrap_next got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00001234 pc=02 a=1",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_redirect_bit0();
      redirect_valid = 1'b1; redirect_pc = 8'h09;
      tick();
      redirect_valid = 1'b0; #1;
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00004501, 8'h08, 6'd2}) begin
         bad++; $display("FAIL redir_bit0 got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00004501 pc=08 a=2",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   task automatic test_reset_priority();
      rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h20; #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL rst_prio_valid got=%b exp=0", out_valid);
      end
      tick();
      rst = 1'b1; redirect_valid = 1'b0; #1;
      total++;
      if ({out_valid, out_is_compressed, out_instr, out_pc, imem_addr} !== {1'b1, 1'b1, 32'h00000050, 8'h00, 6'd0}) begin
         bad++; $display("FAIL rst_prio_out got v=%b c=%b i=%h pc=%h a=%0d exp v=1 c=1 i=00000050 pc=00 a=0",
                         out_valid, out_is_compressed, out_instr, out_pc, imem_addr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h00500093;
      mem[1] = {16'h0001, 16'h0505};
      mem[2] = {16'h0093, 16'h4501};
      mem[3] = {16'h4505, 16'h0050};
      test_reset();
      test_compressed_pair();
      test_split_32();
      test_stall();
      test_redirect_odd();
      test_wrap();
      test_redirect_bit0();
      test_reset_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
